// File: rtl/bdc_pkg.sv
// Shared definitions for the barrel distortion correction front end:
// frame sequencer states, default geometry and the K1 fixed-point format.
package bdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH    = 1920;
    localparam int DEFAULT_HEIGHT   = 1080;
    localparam int DEFAULT_CENTER_X = DEFAULT_WIDTH / 2;
    localparam int DEFAULT_CENTER_Y = DEFAULT_HEIGHT / 2;

    // K1 is signed 4.4 fixed point; the core interprets it the same way.
    localparam int K1_INT_BITS  = 4;
    localparam int K1_FRAC_BITS = 4;
    localparam int K1_WIDTH     = K1_INT_BITS + K1_FRAC_BITS;

endpackage

// File: rtl/bdc_frame_controller_if.sv
// AXI4-Stream video link (tuser = start of frame) used on both sides
// of the frame controller.
interface bdc_frame_controller_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/bdc_shadow_cfg.sv
// Pending/active register pair for correction coefficients: updates are
// staged and only become active on a frame-start commit.
module bdc_shadow_cfg
    import bdc_pkg::*;
#(
    parameter int                     K_WIDTH     = K1_WIDTH,
    parameter int                     COORD_WIDTH = 16,
    parameter logic [K_WIDTH-1:0]     K1_DEFAULT  = 'h40,
    parameter logic [COORD_WIDTH-1:0] CX_DEFAULT  = COORD_WIDTH'(DEFAULT_CENTER_X),
    parameter logic [COORD_WIDTH-1:0] CY_DEFAULT  = COORD_WIDTH'(DEFAULT_CENTER_Y)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   update,
    input  logic                   commit,
    input  logic [K_WIDTH-1:0]     req_k1,
    input  logic [COORD_WIDTH-1:0] req_center_x,
    input  logic [COORD_WIDTH-1:0] req_center_y,
    output logic [K_WIDTH-1:0]     act_k1,
    output logic [COORD_WIDTH-1:0] act_center_x,
    output logic [COORD_WIDTH-1:0] act_center_y
);

    logic                   pending;
    logic [K_WIDTH-1:0]     pend_k1;
    logic [COORD_WIDTH-1:0] pend_center_x;
    logic [COORD_WIDTH-1:0] pend_center_y;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            pend_k1       <= '0;
            pend_center_x <= '0;
            pend_center_y <= '0;
            act_k1        <= K1_DEFAULT;
            act_center_x  <= CX_DEFAULT;
            act_center_y  <= CY_DEFAULT;
        end else if (commit) begin
            // A request arriving on the commit cycle bypasses the pending stage.
            if (update) begin
                act_k1       <= req_k1;
                act_center_x <= req_center_x;
                act_center_y <= req_center_y;
            end else if (pending) begin
                act_k1       <= pend_k1;
                act_center_x <= pend_center_x;
                act_center_y <= pend_center_y;
            end
            pending <= 1'b0;
        end else if (update) begin
            pend_k1       <= req_k1;
            pend_center_x <= req_center_x;
            pend_center_y <= req_center_y;
            pending       <= 1'b1;
        end
    end

endmodule

// File: rtl/bdc_frame_controller.sv
// Frame sequencer in front of the distortion core: admits whole frames,
// checks line/frame geometry and waits for the core before the next frame.
module bdc_frame_controller
    import bdc_pkg::*;
#(
    parameter int                 WIDTH         = DEFAULT_WIDTH,
    parameter int                 HEIGHT        = DEFAULT_HEIGHT,
    parameter int                 DATA_WIDTH    = 24,
    parameter int                 COORD_WIDTH   = 16,
    parameter int                 K_WIDTH       = K1_WIDTH,
    parameter logic [K_WIDTH-1:0] K1_DEFAULT    = 'h40,
    parameter int                 DRAIN_TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_enable,
    input  logic                          cfg_update,
    input  logic [K_WIDTH-1:0]            cfg_k1,
    input  logic [COORD_WIDTH-1:0]        cfg_center_x,
    input  logic [COORD_WIDTH-1:0]        cfg_center_y,
    input  logic                          err_clear,
    bdc_frame_controller_if.slave         s_axis,
    bdc_frame_controller_if.master        m_axis,
    input  logic                          core_frame_done,
    output logic [K_WIDTH-1:0]            act_k1,
    output logic [COORD_WIDTH-1:0]        act_center_x,
    output logic [COORD_WIDTH-1:0]        act_center_y,
    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic                          err_line,
    output logic                          err_sof,
    output logic                          err_timeout
);

    localparam logic [DATA_WIDTH-1:0]  ZERO_PIX   = '0;
    localparam logic [COORD_WIDTH-1:0] X_LAST     = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST     = COORD_WIDTH'(HEIGHT - 1);
    localparam logic [15:0]            TO_LAST    = 16'(DRAIN_TIMEOUT - 1);

    state_t                 state, state_nx;
    logic [COORD_WIDTH-1:0] x_cnt, y_cnt;
    logic [15:0]            to_cnt;
    logic                   pass, s_ready;

    // Output process: routing and ready depend on state and the live beat.
    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        pass    = 1'b0;
        s_ready = 1'b0;
        case (state)
            ST_IDLE:     s_ready = 1'b1;
            ST_WAIT_SOF: begin
                if (cfg_enable && s_axis.tvalid && s_axis.tuser) begin
                    pass    = 1'b1;
                    s_ready = m_axis.tready;
                end else begin
                    s_ready = 1'b1;
                end
            end
            ST_ACTIVE: begin
                pass    = 1'b1;
                s_ready = m_axis.tready;
            end
            default: ;
        endcase
    end

    assign s_axis.tready = rst_n & s_ready;
    assign m_axis.tvalid = pass & s_axis.tvalid;
    assign m_axis.tdata  = pass ? s_axis.tdata : ZERO_PIX;
    assign m_axis.tlast  = pass & s_axis.tlast;
    assign m_axis.tuser  = pass & s_axis.tuser;
    assign busy          = (state == ST_ACTIVE) || (state == ST_DRAIN);

    logic beat_in, sof_commit, act_beat, x_last, line_end, frame_end;
    logic line_err, sof_err, drain_done, drain_to;

    assign beat_in    = pass & s_axis.tvalid & s_ready;
    assign sof_commit = (state == ST_WAIT_SOF) & beat_in;
    assign act_beat   = (state == ST_ACTIVE) & beat_in;
    assign x_last     = (x_cnt == X_LAST);
    assign sof_err    = act_beat & s_axis.tuser;
    assign line_end   = act_beat & ~s_axis.tuser & (s_axis.tlast | x_last);
    assign line_err   = line_end & (s_axis.tlast ^ x_last);
    assign frame_end  = line_end & (y_cnt == Y_LAST);
    assign drain_done = (state == ST_DRAIN) & core_frame_done;
    assign drain_to   = (state == ST_DRAIN) & ~core_frame_done & (to_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (cfg_enable) state_nx = ST_WAIT_SOF;
            ST_WAIT_SOF: begin
                if (!cfg_enable)     state_nx = ST_IDLE;
                else if (sof_commit) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE:   if (frame_end) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_done || drain_to)
                    state_nx = cfg_enable ? ST_WAIT_SOF : ST_IDLE;
            end
            default:     state_nx = ST_IDLE;
        endcase
    end

    // The SOF beat itself is pixel 0, so the next beat is x=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (sof_commit || sof_err) begin
            x_cnt <= COORD_WIDTH'(1);
            y_cnt <= '0;
        end else if (line_end) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
        end else if (act_beat) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 to_cnt <= '0;
        else if (state != ST_DRAIN) to_cnt <= '0;
        else if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          frame_count <= '0;
        else if (drain_done) frame_count <= frame_count + 1'b1;
    end

    // A new error in the same cycle as err_clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_line    <= 1'b0;
            err_sof     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (line_err)       err_line <= 1'b1;
            else if (err_clear) err_line <= 1'b0;
            if (sof_err)        err_sof <= 1'b1;
            else if (err_clear) err_sof <= 1'b0;
            if (drain_to)       err_timeout <= 1'b1;
            else if (err_clear) err_timeout <= 1'b0;
        end
    end

    bdc_shadow_cfg #(
        .K_WIDTH     (K_WIDTH),
        .COORD_WIDTH (COORD_WIDTH),
        .K1_DEFAULT  (K1_DEFAULT),
        .CX_DEFAULT  (COORD_WIDTH'(WIDTH / 2)),
        .CY_DEFAULT  (COORD_WIDTH'(HEIGHT / 2))
    ) u_shadow_cfg (
        .clk          (clk),
        .rst_n        (rst_n),
        .update       (cfg_update),
        .commit       (sof_commit),
        .req_k1       (cfg_k1),
        .req_center_x (cfg_center_x),
        .req_center_y (cfg_center_y),
        .act_k1       (act_k1),
        .act_center_x (act_center_x),
        .act_center_y (act_center_y)
    );

endmodule

// File: tb/tb_bdc_frame_controller.sv
// Directed bench for bdc_frame_controller on an 8x4 frame with a short
// drain timeout: vector table for the first frame, hand sequences after.
module tb_bdc_frame_controller;

    localparam int DW = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable, cfg_update, err_clear, core_frame_done;
    logic [7:0]  cfg_k1;
    logic [15:0] cfg_center_x, cfg_center_y;
    logic [7:0]  act_k1;
    logic [15:0] act_center_x, act_center_y, frame_count;
    logic        busy, err_line, err_sof, err_timeout;

    bdc_frame_controller_if #(.DATA_WIDTH(DW)) s_if ();
    bdc_frame_controller_if #(.DATA_WIDTH(DW)) m_if ();

    bdc_frame_controller #(
        .WIDTH(8), .HEIGHT(4), .DATA_WIDTH(DW), .COORD_WIDTH(16),
        .K_WIDTH(8), .K1_DEFAULT(8'h40), .DRAIN_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_enable(cfg_enable), .cfg_update(cfg_update),
        .cfg_k1(cfg_k1), .cfg_center_x(cfg_center_x), .cfg_center_y(cfg_center_y),
        .err_clear(err_clear),
        .s_axis(s_if), .m_axis(m_if),
        .core_frame_done(core_frame_done),
        .act_k1(act_k1), .act_center_x(act_center_x), .act_center_y(act_center_y),
        .busy(busy), .frame_count(frame_count),
        .err_line(err_line), .err_sof(err_sof), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pix_seq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the last accepting edge.
    task automatic send_beats(input int n, input bit sof_first, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = DW'(32'h00AB0000 + pix_seq);
            s_if.tuser  = sof_first && (i == 0);
            s_if.tlast  = last_on_end && (i == n - 1);
            pix_seq++;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain_then_done(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("drain_s_tready", 32'(s_if.tready), 32'd0);
            if (i == n - 1) core_frame_done = 1'b1;
            @(posedge clk); #1;
            core_frame_done = 1'b0;
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          valid, last, user, mready, upd;
        logic          exp_sready, exp_mvalid;
        logic [DW-1:0] exp_mdata;
    } vec_t;

    vec_t vecs [34];

    initial begin : stim
        int beat;
        int to_cycles;

        // Row 0: stray non-SOF beat in WAIT_SOF; row 4: beat 3 stalled by the core.
        vecs[0].data = 24'hDEAD01; vecs[0].valid = 1'b1; vecs[0].last = 1'b0;
        vecs[0].user = 1'b0; vecs[0].mready = 1'b1; vecs[0].upd = 1'b0;
        vecs[0].exp_sready = 1'b1; vecs[0].exp_mvalid = 1'b0; vecs[0].exp_mdata = '0;
        for (int r = 1; r < 34; r++) begin
            beat = (r <= 4) ? r - 1 : r - 2;
            vecs[r].data       = 24'hC00000 | DW'(beat);
            vecs[r].valid      = 1'b1;
            vecs[r].last       = (beat % 8) == 7;
            vecs[r].user       = (beat == 0);
            vecs[r].mready     = (r != 4);
            vecs[r].upd        = (beat == 12) && (r != 4);
            vecs[r].exp_sready = (r != 4);
            vecs[r].exp_mvalid = 1'b1;
            vecs[r].exp_mdata  = 24'hC00000 | DW'(beat);
        end

        rst_n = 1'b0; cfg_enable = 1'b0; cfg_update = 1'b0; err_clear = 1'b0;
        core_frame_done = 1'b0; cfg_k1 = 8'h20; cfg_center_x = 16'd11; cfg_center_y = 16'd7;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;

        #12;
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_act_k1", 32'(act_k1), 32'h40);
        check("rst_center_x", 32'(act_center_x), 32'd4);
        check("rst_center_y", 32'(act_center_y), 32'd2);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", {29'd0, err_line, err_sof, err_timeout}, 32'd0);

        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_s_tready", 32'(s_if.tready), 32'd1);
        cfg_enable = 1'b1;
        @(posedge clk); #1;

        // Frame 1: clean geometry, mid-frame cfg_update must stay pending.
        for (int r = 0; r < 34; r++) begin
            s_if.tdata  = vecs[r].data;
            s_if.tvalid = vecs[r].valid;
            s_if.tlast  = vecs[r].last;
            s_if.tuser  = vecs[r].user;
            m_if.tready = vecs[r].mready;
            cfg_update  = vecs[r].upd;
            @(negedge clk);
            check($sformatf("vec%0d_m_tvalid", r), 32'(m_if.tvalid), 32'(vecs[r].exp_mvalid));
            check($sformatf("vec%0d_m_tdata", r), 32'(m_if.tdata), 32'(vecs[r].exp_mdata));
            check($sformatf("vec%0d_s_tready", r), 32'(s_if.tready), 32'(vecs[r].exp_sready));
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        cfg_update = 1'b0; m_if.tready = 1'b1;
        cfg_k1 = 8'h55; cfg_center_x = 16'd99; cfg_center_y = 16'd98;
        check("f1_busy_drain", 32'(busy), 32'd1);
        check("f1_k1_held", 32'(act_k1), 32'h40);
        drain_then_done(5);
        check("f1_s_tready_after", 32'(s_if.tready), 32'd1);
        check("f1_frame_count", 32'(frame_count), 32'd1);
        check("f1_errs", {29'd0, err_line, err_sof, err_timeout}, 32'd0);

        // Frame 2: pending config commits on SOF; short line 1 flags err_line.
        send_beats(8, 1'b1, 1'b1);
        check("f2_k1_commit", 32'(act_k1), 32'h20);
        check("f2_cx_commit", 32'(act_center_x), 32'd11);
        check("f2_cy_commit", 32'(act_center_y), 32'd7);
        send_beats(6, 1'b0, 1'b1);
        check("f2_err_line", 32'(err_line), 32'd1);
        send_beats(8, 1'b0, 1'b1);
        send_beats(7, 1'b0, 1'b0);
        check("f2_still_active", 32'(s_if.tready), 32'd1);
        send_beats(1, 1'b0, 1'b1);
        check("f2_in_drain", 32'(s_if.tready), 32'd0);
        drain_then_done(2);
        check("f2_frame_count", 32'(frame_count), 32'd2);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check("f2_err_line_cleared", 32'(err_line), 32'd0);

        // Frame 3: update on the SOF cycle applies at once; SOF at beat 10 restarts.
        cfg_k1 = 8'h30; cfg_update = 1'b1;
        send_beats(1, 1'b1, 1'b0);
        cfg_update = 1'b0;
        check("f3_k1_same_cycle", 32'(act_k1), 32'h30);
        send_beats(7, 1'b0, 1'b1);
        send_beats(2, 1'b0, 1'b0);
        check("f3_no_err_sof_yet", 32'(err_sof), 32'd0);
        send_beats(1, 1'b1, 1'b0);
        check("f3_err_sof", 32'(err_sof), 32'd1);
        check("f3_k1_unchanged", 32'(act_k1), 32'h30);
        send_beats(7, 1'b0, 1'b1);
        cfg_enable = 1'b0;
        send_beats(8, 1'b0, 1'b1);
        send_beats(8, 1'b0, 1'b1);
        send_beats(7, 1'b0, 1'b0);
        check("f3_still_active", 32'(s_if.tready), 32'd1);
        send_beats(1, 1'b0, 1'b1);
        check("f3_in_drain", 32'(s_if.tready), 32'd0);
        drain_then_done(3);
        check("f3_frame_count", 32'(frame_count), 32'd3);
        check("f3_idle_busy", 32'(busy), 32'd0);
        s_if.tvalid = 1'b1; s_if.tuser = 1'b1; s_if.tdata = 24'h777777;
        @(negedge clk);
        check("f3_idle_drop_sof", 32'(m_if.tvalid), 32'd0);
        check("f3_idle_s_tready", 32'(s_if.tready), 32'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
        cfg_enable = 1'b1;
        @(posedge clk); #1;

        // Frame 4: no core_frame_done, drain times out after 20 cycles.
        send_beats(8, 1'b1, 1'b1);
        check("f4_k1_no_pending", 32'(act_k1), 32'h30);
        send_beats(8, 1'b0, 1'b1);
        send_beats(8, 1'b0, 1'b1);
        send_beats(8, 1'b0, 1'b1);
        to_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_if.tready) break;
            to_cycles++;
        end
        check("f4_drain_cycles", 32'(to_cycles), 32'd20);
        check("f4_err_timeout", 32'(err_timeout), 32'd1);
        check("f4_frame_count", 32'(frame_count), 32'd3);
        check("f4_busy", 32'(busy), 32'd0);

        // Reset mid-ACTIVE, then non-SOF data is dropped until a new SOF.
        @(posedge clk); #1;
        s_if.tvalid = 1'b1; s_if.tuser = 1'b1; s_if.tdata = 24'h5A5A5A;
        @(negedge clk);
        check("f5_sof_fwd", 32'(m_if.tvalid), 32'd1);
        check("f5_sof_data", 32'(m_if.tdata), 32'h5A5A5A);
        @(posedge clk); #1;
        s_if.tuser = 1'b0;
        send_beats(3, 1'b0, 1'b0);
        s_if.tvalid = 1'b1; s_if.tdata = 24'h123456;
        check("f5_busy_active", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
        check("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("mid_rst_m_tdata", 32'(m_if.tdata), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_errs", {29'd0, err_line, err_sof, err_timeout}, 32'd0);
        check("mid_rst_act_k1", 32'(act_k1), 32'h40);
        check("mid_rst_center_x", 32'(act_center_x), 32'd4);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_drop%0d_m_tvalid", i), 32'(m_if.tvalid), 32'd0);
            check($sformatf("post_rst_drop%0d_s_tready", i), 32'(s_if.tready), 32'd1);
        end
        @(posedge clk); #1;
        s_if.tuser = 1'b1;
        @(negedge clk);
        check("post_rst_sof_fwd", 32'(m_if.tvalid), 32'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
